// File: rtl/dmem_byte_responder_if.sv
// Pipeline-side request/response bundle of the MEM-stage data-memory responder.
// master = pipeline (drives the request), slave = responder.
interface dmem_byte_responder_if #(
  parameter int XLEN = 32
);
  logic            MemReadEn;
  logic            MemWriteEn;
  logic [1:0]      MemSize;
  logic [1:0]      LoadSize;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            mem_stall;
  logic [XLEN-1:0] rdata;
  logic            rdata_valid;
  logic            misalign_err;

  modport master (
    output MemReadEn, MemWriteEn, MemSize, LoadSize, addr, wdata,
    input  mem_stall, rdata, rdata_valid, misalign_err
  );

  modport slave (
    input  MemReadEn, MemWriteEn, MemSize, LoadSize, addr, wdata,
    output mem_stall, rdata, rdata_valid, misalign_err
  );
endinterface

// File: rtl/dmem_byte_responder.sv
// Serialises 32-bit loads/stores onto a byte-wide synchronous SRAM, little-endian,
// stalling the pipeline until done; loads are sign-extended per LoadSize.
module dmem_byte_responder #(
  parameter int ADDR_W = 10,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  dmem_byte_responder_if.slave bus,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata,
  output logic [2:0]        dbg_state
);

  // Handshake: a request (MemReadEn|MemWriteEn) is taken only in IDLE; the
  // upstream holds it stable while mem_stall=1 and the access completes in the
  // one cycle where state is DONE (mem_stall=0), after which the FSM returns to
  // IDLE without re-accepting the still-present request.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_RWAIT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [1:0]        lsize_q, lsize_d;
  logic              is_load_q, is_load_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   asm_q, asm_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic              req;
  logic              bad_align;
  logic [2:0]        nbytes_in;
  logic              last_byte;
  logic [1:0]        cap_idx;
  logic [XLEN-1:0]   asm_cap;

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input logic [1:0] ls);
    logic [XLEN-1:0] r;
    case (ls)
      2'b00:   r = {{24{v[7]}}, v[7:0]};
      2'b01:   r = {{16{v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nbytes_d  = nbytes_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    lsize_d   = lsize_q;
    is_load_d = is_load_q;
    err_d     = err_q;
    asm_d     = asm_q;
    rdata_d   = rdata_q;

    req       = bus.MemReadEn | bus.MemWriteEn;
    bad_align = (bus.MemSize == 2'b11) ||
                (bus.MemSize == 2'b01 && bus.addr[0]) ||
                (bus.MemSize == 2'b10 && bus.addr[1:0] != 2'b00);
    case (bus.MemSize)
      2'b00:   nbytes_in = 3'd1;
      2'b01:   nbytes_in = 3'd2;
      default: nbytes_in = 3'd4;
    endcase
    last_byte = (cnt_q == nbytes_q - 3'd1);

    // The SRAM returns the byte issued last cycle, i.e. byte index cnt-1.
    cap_idx = 2'(cnt_q - 3'd1);
    asm_cap = asm_q;
    asm_cap[{cap_idx, 3'b000} +: 8] = sram_rdata;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          base_d    = bus.addr[ADDR_W-1:0];
          wdata_d   = bus.wdata;
          nbytes_d  = nbytes_in;
          lsize_d   = bus.LoadSize;
          cnt_d     = 3'd0;
          asm_d     = '0;
          is_load_d = ~bus.MemWriteEn;
          err_d     = bad_align;
          if (bad_align)           state_d = S_DONE;
          else if (bus.MemWriteEn) state_d = S_WRITE;
          else                     state_d = S_READ;
        end
      end
      S_WRITE: begin
        cnt_d = cnt_q + 3'd1;
        if (last_byte) state_d = S_DONE;
      end
      S_READ: begin
        if (cnt_q != 3'd0) asm_d = asm_cap;
        cnt_d = cnt_q + 3'd1;
        if (last_byte) state_d = S_RWAIT;
      end
      S_RWAIT: begin
        asm_d   = asm_cap;
        rdata_d = extend(asm_cap, lsize_q);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      nbytes_q  <= '0;
      base_q    <= '0;
      wdata_q   <= '0;
      lsize_q   <= '0;
      is_load_q <= 1'b0;
      err_q     <= 1'b0;
      asm_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nbytes_q  <= nbytes_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      lsize_q   <= lsize_d;
      is_load_q <= is_load_d;
      err_q     <= err_d;
      asm_q     <= asm_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (state_q == S_WRITE || state_q == S_READ) begin
      sram_en   = 1'b1;
      sram_we   = (state_q == S_WRITE);
      sram_addr = base_q + ADDR_W'(cnt_q);
      if (state_q == S_WRITE) sram_wdata = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    end
  end

  assign bus.mem_stall    = (state_q != S_IDLE && state_q != S_DONE) || (state_q == S_IDLE && req);
  assign bus.rdata        = rdata_q;
  assign bus.rdata_valid  = (state_q == S_DONE) && is_load_q && !err_q;
  assign bus.misalign_err = (state_q == S_DONE) && err_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_dmem_byte_responder.sv
// Self-checking bench: byte SRAM model, reference memory image, scoreboard queues
// for expected store bytes and load results.
module tb_dmem_byte_responder;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sram_en, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_wdata;
  logic [7:0]        sram_rdata = 8'h00;
  logic [2:0]        dbg_state;

  dmem_byte_responder_if #(.XLEN(32)) bus ();

  dmem_byte_responder #(.ADDR_W(ADDR_W), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  logic [7:0] sram_mem  [0:(1<<ADDR_W)-1];
  logic [7:0] model_mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  logic [31:0] exp_q[$];
  logic [17:0] wexp_q[$];
  int          n_checks = 0;
  int          n_bad    = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [31:0] v, input logic [1:0] ls);
    if (ls == 2'b00) return {{24{v[7]}}, v[7:0]};
    if (ls == 2'b01) return {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic idle_inputs();
    bus.MemReadEn  = 1'b0;
    bus.MemWriteEn = 1'b0;
    bus.MemSize    = 2'b00;
    bus.LoadSize   = 2'b00;
    bus.addr       = 32'h0;
    bus.wdata      = 32'h0;
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [1:0] msz,
                           input logic [1:0] lsz, input logic [31:0] a, input logic [31:0] wd);
    int          n, lat, cyc, en_cnt;
    logic        bad, done;
    logic [9:0]  ba;
    logic [31:0] v;
    logic [17:0] w;
    n   = (msz == 2'b00) ? 1 : (msz == 2'b01) ? 2 : 4;
    bad = (msz == 2'b11) || (msz == 2'b01 && a[0]) || (msz == 2'b10 && a[1:0] != 2'b00);
    lat = bad ? 1 : (wr ? n + 1 : n + 2);
    if (!bad && wr) begin
      for (int k = 0; k < n; k++) begin
        ba = 10'(a + 32'(k));
        wexp_q.push_back({ba, wd[8*k +: 8]});
        model_mem[ba] = wd[8*k +: 8];
      end
    end
    if (!bad && !wr) begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = model_mem[10'(a + 32'(k))];
      v = ext_model(v, lsz);
      exp_q.push_back(v);
    end

    @(negedge clk);
    bus.MemReadEn = rd; bus.MemWriteEn = wr; bus.MemSize = msz;
    bus.LoadSize = lsz; bus.addr = a; bus.wdata = wd;
    #1;
    check("stall_req", {31'h0, bus.mem_stall}, 32'h1);
    cyc = 0; en_cnt = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
      if (!bus.mem_stall) done = 1'b1;
      else begin
        if (sram_en) en_cnt++;
        if (sram_en && sram_we) begin
          if (wexp_q.size() > 0) begin
            w = wexp_q.pop_front();
            check("wr_addr", 32'(sram_addr), 32'(w[17:8]));
            check("wr_byte", 32'(sram_wdata), 32'(w[7:0]));
          end else check("wr_unexpected", 32'(sram_addr), 32'hFFFF_FFFF);
        end
      end
    end
    check("done_seen", {31'h0, done}, 32'h1);
    check("latency", 32'(cyc), 32'(lat));
    check("sram_cycles", 32'(en_cnt), bad ? 32'h0 : 32'(n));
    check("misalign_err", {31'h0, bus.misalign_err}, {31'h0, bad});
    check("rdata_valid", {31'h0, bus.rdata_valid}, {31'h0, (!bad && !wr)});
    if (bus.rdata_valid) begin
      if (exp_q.size() > 0) begin
        v = exp_q.pop_front();
        check("rdata", bus.rdata, v);
        last_rdata = v;
      end else check("rdata_unexpected", bus.rdata, 32'hFFFF_FFFF);
    end else begin
      check("rdata_hold", bus.rdata, last_rdata);
    end
    idle_inputs();
    @(negedge clk);
    #1;
    check("back_idle", 32'(dbg_state), 32'h0);
    check("wq_drained", 32'(wexp_q.size()), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, {31'h0, bus.mem_stall}, 32'h0);
    check({tag, "_en"},    {31'h0, sram_en}, 32'h0);
    check({tag, "_we"},    {31'h0, sram_we}, 32'h0);
    check({tag, "_addr"},  32'(sram_addr), 32'h0);
    check({tag, "_wdata"}, 32'(sram_wdata), 32'h0);
    check({tag, "_rdata"}, bus.rdata, 32'h0);
    check({tag, "_rvld"},  {31'h0, bus.rdata_valid}, 32'h0);
    check({tag, "_merr"},  {31'h0, bus.misalign_err}, 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'h0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  sz, ls;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      sram_mem[i]  = 8'h00;
      model_mem[i] = 8'h00;
    end
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    do_access(1'b0, 1'b1, 2'b10, 2'b10, 32'h10, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 2'b10, 2'b10, 32'h10, 32'h0);
    do_access(1'b0, 1'b1, 2'b00, 2'b00, 32'h21, 32'h80);
    do_access(1'b1, 1'b0, 2'b00, 2'b00, 32'h21, 32'h0);
    do_access(1'b1, 1'b0, 2'b01, 2'b01, 32'h20, 32'h0);
    // rejected accesses
    do_access(1'b1, 1'b0, 2'b01, 2'b01, 32'h11, 32'h0);
    do_access(1'b0, 1'b1, 2'b10, 2'b10, 32'h12, 32'h12345678);
    do_access(1'b1, 1'b0, 2'b11, 2'b10, 32'h10, 32'h0);
    // top of memory and ignored upper address bits
    do_access(1'b0, 1'b1, 2'b10, 2'b10, 32'h0000_03FC, 32'hCAFEF00D);
    do_access(1'b1, 1'b0, 2'b10, 2'b10, 32'h0001_03FC, 32'h0);
    // store wins when both are requested
    do_access(1'b1, 1'b1, 2'b10, 2'b10, 32'h30, 32'h8765A1B2);
    do_access(1'b1, 1'b0, 2'b10, 2'b01, 32'h30, 32'h0);
    // byte load with lw extension: upper bytes read as zero
    do_access(1'b1, 1'b0, 2'b00, 2'b10, 32'h33, 32'h0);

    for (int i = 0; i < 6; i++) begin
      a  = 32'h100 + (32'($urandom_range(0, 63)) << 2);
      d  = $urandom;
      sz = 2'($urandom_range(0, 2));
      ls = 2'($urandom_range(0, 3));
      do_access(1'b0, 1'b1, sz, 2'b00, a, d);
      sz = 2'($urandom_range(0, 2));
      do_access(1'b1, 1'b0, sz, ls, a, 32'h0);
    end

    // reset in the middle of a word store
    @(negedge clk);
    bus.MemWriteEn = 1'b1; bus.MemSize = 2'b10; bus.addr = 32'h40; bus.wdata = 32'h11223344;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_state", 32'(dbg_state), 32'h1);
    check("mid_addr", 32'(sram_addr), 32'h41);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    last_rdata = 32'h0;
    do_access(1'b1, 1'b0, 2'b10, 2'b10, 32'h10, 32'h0);

    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
